// File: rtl/core_ctrl_fsm_pkg.sv
// rtl/core_ctrl_fsm_pkg.sv - shared opcodes, state encoding and select encodings for the core sequencer
// Contents: RV32I major opcodes, sequencer state enum, pc_sel / wb_sel codes,
//           and is_legal() which classifies the opcodes the sequencer can execute.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    // pc_sel: next-PC source
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_RS1   = 2'd2;

    // wb_sel: register-file write data source
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// rtl/core_ctrl_fsm_if.sv - instruction/data memory req/ack handshake bundle
// Signals: imem_req/imem_ack (instruction fetch), dmem_req/dmem_we/dmem_ack (data access).
// master = sequencer side, slave = memory side.
interface core_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/core_ctrl_fsm_mem_wait_timer.sv
// rtl/core_ctrl_fsm_mem_wait_timer.sv - bounded wait counter for a memory req/ack handshake
// Ports: clk, rst_n (sync active-low), clr (restart count), req, ack,
//        expired (req still unanswered on its last allowed cycle).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (req && !ack) begin
            cnt <= cnt + 8'd1;
        end
    end

    // An ack arriving on the last cycle masks expiry, so the transfer completes normally.
    assign expired = req && !ack && (cnt == LAST);

endmodule

// File: rtl/core_ctrl_fsm.sv
// rtl/core_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I semi-core
// Ports: clk, rst_n (sync active-low); opcode, branch_taken from datapath;
//        mem (master handshake to imem/dmem); ir_load, reg_we, pc_we, pc_sel, wb_sel strobes;
//        retire pulse, instret counter, sticky illegal / bus_err trap flags.
module core_ctrl_fsm
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    core_ctrl_fsm_if.master  mem,
    output logic             ir_load,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             bus_err
);

    state_t state, nxt;
    logic   imem_req_c, dmem_req_c, dmem_we_c;
    logic   set_illegal, set_bus_err;
    logic   wait_req, wait_ack, wait_clr, expired;

    // One timer serves both handshakes since only one can be pending at a time.
    assign wait_req = (state == ST_FETCH) || (state == ST_MEM);
    assign wait_ack = (state == ST_FETCH) ? mem.imem_ack : mem.dmem_ack;
    assign wait_clr = (nxt != state) && ((nxt == ST_FETCH) || (nxt == ST_MEM));

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .req     (wait_req),
        .ack     (wait_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            instret <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= nxt;
            if (retire)      instret <= instret + CNT_W'(1);
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
        end
    end

    always_comb begin
        nxt         = state;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_load     = 1'b0;
        reg_we      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        wb_sel      = WB_ALU;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ack) begin
                    ir_load = 1'b1;
                    nxt     = ST_DECODE;
                end else if (expired) begin
                    set_bus_err = 1'b1;
                    nxt         = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode)) begin
                    nxt = ST_EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    nxt         = ST_TRAP;
                end
            end
            ST_EXECUTE: begin
                // Branches finish here: no register write and no memory phase.
                if (opcode == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                    nxt    = ST_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    nxt = ST_MEM;
                end else begin
                    nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OP_STORE);
                if (mem.dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        nxt    = ST_FETCH;
                    end else begin
                        nxt = ST_WB;
                    end
                end else if (expired) begin
                    set_bus_err = 1'b1;
                    nxt         = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                nxt    = ST_FETCH;
                case (opcode)
                    OP_LOAD: wb_sel = WB_MEM;
                    OP_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
                    OP_JALR: begin wb_sel = WB_PC4; pc_sel = PC_RS1; end
                    default: ;
                endcase
            end
            ST_TRAP: ;
            default: nxt = ST_FETCH;
        endcase

        // Strobes are forced low during reset so an in-flight req is dropped, not completed.
        if (!rst_n) begin
            imem_req_c  = 1'b0;
            dmem_req_c  = 1'b0;
            dmem_we_c   = 1'b0;
            ir_load     = 1'b0;
            reg_we      = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = PC_PLUS4;
            wb_sel      = WB_ALU;
            retire      = 1'b0;
            set_illegal = 1'b0;
            set_bus_err = 1'b0;
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb/tb_core_ctrl_fsm.sv - self-checking bench for core_ctrl_fsm
module tb_core_ctrl_fsm;
    import core_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             ir_load, reg_we, pc_we, retire, illegal, bus_err;
    logic [1:0]       pc_sel, wb_sel;
    logic [CNT_W-1:0] instret;

    always #5 clk = ~clk;

    core_ctrl_fsm_if bus();

    core_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (bus),
        .ir_load      (ir_load),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .instret      (instret),
        .illegal      (illegal),
        .bus_err      (bus_err)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        bt;
        logic        ia;
        logic        da;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   n;

    // Packed output view: {imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, pc_sel, wb_sel, retire}
    function automatic logic [10:0] o(input logic ireq, input logic irl, input logic dreq,
                                      input logic dwe, input logic rwe, input logic pwe,
                                      input logic [1:0] ps, input logic [1:0] ws, input logic ret);
        return {ireq, irl, dreq, dwe, rwe, pwe, ps, ws, ret};
    endfunction

    function automatic logic [10:0] cur();
        return {bus.imem_req, ir_load, bus.dmem_req, bus.dmem_we, reg_we, pc_we,
                pc_sel, wb_sel, retire};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic bt, input logic ia,
                       input logic da, input logic [10:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.bt = bt; v.ia = ia; v.da = da; v.exp = e;
        vecs.push_back(v);
    endtask

    // FETCH with immediate ack, then the idle DECODE cycle
    task automatic add_fd(input logic [6:0] op);
        add(1'b1, op, 1'b0, 1'b1, 1'b0, o(1, 1, 0, 0, 0, 0, PC_PLUS4, WB_ALU, 0));
        add(1'b1, op, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [10:0] none, fwait, fack, mreq;
        none  = '0;
        fwait = o(1, 0, 0, 0, 0, 0, PC_PLUS4, WB_ALU, 0);
        fack  = o(1, 1, 0, 0, 0, 0, PC_PLUS4, WB_ALU, 0);
        mreq  = o(0, 0, 1, 0, 0, 0, PC_PLUS4, WB_ALU, 0);

        // reset
        add(0, OP_IALU, 0, 0, 0, none);
        add(0, OP_IALU, 0, 1, 1, none);
        // LOAD interrupted by reset while in MEM: no retire, back to FETCH
        add_fd(OP_LOAD);
        add(1, OP_LOAD, 0, 0, 0, none);
        add(1, OP_LOAD, 0, 0, 0, mreq);
        add(0, OP_LOAD, 0, 0, 1, none);
        // ADDI
        add_fd(OP_IALU);
        add(1, OP_IALU, 0, 0, 0, none);
        add(1, OP_IALU, 0, 0, 0, o(0, 0, 0, 0, 1, 1, PC_PLUS4, WB_ALU, 1));
        // BEQ taken, BEQ not taken
        add_fd(OP_BRANCH);
        add(1, OP_BRANCH, 1, 0, 0, o(0, 0, 0, 0, 0, 1, PC_IMM, WB_ALU, 1));
        add_fd(OP_BRANCH);
        add(1, OP_BRANCH, 0, 0, 0, o(0, 0, 0, 0, 0, 1, PC_PLUS4, WB_ALU, 1));
        // LOAD with ack delayed 3 cycles
        add_fd(OP_LOAD);
        add(1, OP_LOAD, 0, 0, 0, none);
        for (int i = 0; i < 3; i++) add(1, OP_LOAD, 0, 0, 0, mreq);
        add(1, OP_LOAD, 0, 0, 1, mreq);
        add(1, OP_LOAD, 0, 0, 0, o(0, 0, 0, 0, 1, 1, PC_PLUS4, WB_MEM, 1));
        // STORE
        add_fd(OP_STORE);
        add(1, OP_STORE, 0, 0, 0, none);
        add(1, OP_STORE, 0, 0, 1, o(0, 0, 1, 1, 0, 1, PC_PLUS4, WB_ALU, 1));
        // JAL, JALR
        add_fd(OP_JAL);
        add(1, OP_JAL, 0, 0, 0, none);
        add(1, OP_JAL, 0, 0, 0, o(0, 0, 0, 0, 1, 1, PC_IMM, WB_PC4, 1));
        add_fd(OP_JALR);
        add(1, OP_JALR, 0, 0, 0, none);
        add(1, OP_JALR, 0, 0, 0, o(0, 0, 0, 0, 1, 1, PC_RS1, WB_PC4, 1));
        // LUI with one fetch wait cycle
        add(1, OP_LUI, 0, 0, 0, fwait);
        add_fd(OP_LUI);
        add(1, OP_LUI, 0, 0, 0, none);
        add(1, OP_LUI, 0, 0, 0, o(0, 0, 0, 0, 1, 1, PC_PLUS4, WB_ALU, 1));

        foreach (vecs[i]) begin
            rst_n        = vecs[i].rst;
            opcode       = vecs[i].op;
            branch_taken = vecs[i].bt;
            bus.imem_ack = vecs[i].ia;
            bus.dmem_ack = vecs[i].da;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(cur()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end
        chk("instret_after_table", 32'(instret), 32'd8);
        chk("illegal_clear", 32'(illegal), 32'd0);
        chk("bus_err_clear", 32'(bus_err), 32'd0);

        // Fetch timeout: ack withheld
        opcode = OP_IALU; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.imem_req) break;
            n++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", 32'(n), 32'd16);
        chk("timeout_bus_err", 32'(bus_err), 32'd1);
        chk("timeout_trap_outputs", 32'(cur()), 32'd0);
        chk("timeout_no_illegal", 32'(illegal), 32'd0);
        bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("trap_hold_bus", 32'(cur()), 32'd0);
        end
        chk("bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset clears trap; then ack on the 16th request cycle wins
        @(posedge clk); #1;
        rst_n = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(cur()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        chk("reset_fetch", 32'(cur()), 32'(fwait));
        @(posedge clk); #1;
        repeat (14) @(posedge clk);
        #1;
        bus.imem_ack = 1'b1;
        @(negedge clk);
        chk("ack_at_limit", 32'(cur()), 32'(fack));
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("ack_at_limit_decode", 32'(cur()), 32'd0);
        chk("ack_at_limit_no_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ack_at_limit_wb", 32'(cur()), 32'(o(0, 0, 0, 0, 1, 1, PC_PLUS4, WB_ALU, 1)));
        @(posedge clk); #1;
        chk("ack_at_limit_instret", 32'(instret), 32'd1);

        // Illegal opcode traps after DECODE
        opcode = 7'b1110011; bus.imem_ack = 1'b1;
        @(negedge clk);
        chk("illegal_fetch", 32'(cur()), 32'(fack));
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("illegal_decode", 32'(cur()), 32'd0);
        @(posedge clk); #1;
        bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
        @(negedge clk);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("illegal_no_bus_err", 32'(bus_err), 32'd0);
        repeat (3) begin
            chk("illegal_trap_quiet", 32'(cur()), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("illegal_cleared", 32'(illegal), 32'd0);
        chk("illegal_reset_instret", 32'(instret), 32'd1 - 32'd1);
        chk("illegal_reset_fetch", 32'(cur()), 32'(fwait));

        // instret wrap with CNT_W = 4: 15 branches reach all-ones, the 16th wraps to 0
        @(posedge clk); #1;
        opcode = OP_BRANCH; branch_taken = 1'b0; bus.imem_ack = 1'b1;
        repeat (15) begin
            repeat (3) @(posedge clk);
            #1;
        end
        chk("instret_all_ones", 32'(instret), 32'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("instret_wrap", 32'(instret), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I semi-core.
- Drives instruction fetch, decode, execute, memory and writeback steps around the combinational instruction decoder, ALU, register file and PC register.
- Uses req/ack handshakes with instruction and data memories, with a bounded wait timeout.
- Counts retired instructions and traps on illegal opcodes or bus timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory req may wait for ack before trapping (range 2..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  7  decoded instr[6:0] from the current IR.
- branch_taken  in  1  ALU compare result for the current BRANCH; valid in EXECUTE.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load instruction register (pulse).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write; 1 only with dmem_req for STORE.
- reg_we  out  1  register-file WriteBackEn (pulse).
- pc_we  out  1  PC update strobe (pulse).
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch taken/JAL), 2 = rs1+imm (JALR).
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count; wraps to 0.
- illegal  out  1  sticky: unsupported opcode trapped.
- bus_err  out  1  sticky: memory timeout trapped.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. All outputs registered or Moore-decoded from state plus the listed inputs.
- Reset (rst_n = 0 at a clock edge):
  - state = FETCH, instret = 0, illegal = bus_err = 0, wait counter = 0.
  - All strobes and selects are 0 while rst_n is low.
  - Reset mid-operation abandons any pending req without completing it.
- FETCH:
  - imem_req = 1, held until imem_ack.
  - On imem_ack: ir_load = 1 in the same cycle; next state DECODE.
- DECODE (1 cycle):
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC.
  - Legal opcode -> EXECUTE. Any other opcode -> TRAP with illegal = 1.
- EXECUTE (1 cycle):
  - BRANCH: pc_we = 1, pc_sel = branch_taken ? 1 : 0, retire = 1, next FETCH.
  - LOAD/STORE: next MEM.
  - All other legal opcodes: next WB.
- MEM:
  - dmem_req = 1, dmem_we = (opcode == STORE), held until dmem_ack.
  - STORE ack: pc_we = 1, pc_sel = 0, retire = 1, next FETCH.
  - LOAD ack: next WB.
- WB (1 cycle): reg_we = 1, pc_we = 1, retire = 1, next FETCH.
  - wb_sel: LOAD = 1; JAL/JALR = 2; otherwise 0.
  - pc_sel: JAL = 1; JALR = 2; otherwise 0.
  - rd == x0 still asserts reg_we; the register file discards the write.
- Latency without stalls:
  - BRANCH 3 cycles; ALU/LUI/AUIPC/JAL/JALR 4; STORE 4; LOAD 5.
  - Each memory wait cycle adds 1.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM.
  - It increments on each cycle with req high and ack low.
  - When it equals MEM_TIMEOUT-1 with no ack, the next state is TRAP with bus_err = 1.
  - Ack in that same cycle wins: normal transition, no error.
- TRAP:
  - All strobes and requests are 0; illegal/bus_err hold their values.
  - TRAP is exited only by reset.
- instret increments by 1 on every retire pulse and wraps from all-ones to 0.
- pc_we and reg_we never assert in the same cycle as ir_load.

Decomposition:
- Shared package core_pkg holds:
  - opcode localparams;
  - state encoding;
  - pc_sel and wb_sel encodings.
- Sub-module mem_wait_timer holds the wait counter and timeout compare, parameterised by MEM_TIMEOUT, with inputs clr, req, ack and output expired.

Test Plan:
- Reset, then ADDI (0010011) with imem_ack on the first cycle -> imem_req at cycle 0, ir_load at 0, reg_we + pc_we + retire at cycle 3, wb_sel = 0, instret = 1.
- BEQ (1100011) with branch_taken = 1, then again with 0 -> pc_sel = 1, then 0, at EXECUTE; reg_we never asserts; instret += 2.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we = 0, then WB with wb_sel = 1; total 8 cycles. STORE -> dmem_we = 1, no reg_we.
- imem_ack withheld, MEM_TIMEOUT = 16 -> after 16 req cycles enters TRAP, bus_err = 1, imem_req = 0. Repeat with ack on cycle 16 -> normal DECODE.
- Opcode 1110011 -> TRAP after DECODE, illegal = 1, no further requests until rst_n is low for one edge, after which all outputs clear.
- JAL then JALR -> wb_sel = 2 with pc_sel = 1 and 2 respectively. Preload instret to all-ones via a 2^CNT_W run with CNT_W = 4 -> wraps to 0.
